next_pc_gen: RTL and testbench
==============================

Name: next_pc_gen

Overview:
- Parametrised next-instruction-pointer generator at the front of the mig-u fetch pipe.
- Generalises the single-increment next-IP block in four ways: multi-instruction aligned fetch groups, valid/ready backpressure, prioritised exception/branch redirects with an epoch tag for squashing wrong-path fetches, and a halt/resume mode for debug/WFI.
- Drives the fetch unit's address port; redirects come from execute/commit.

Parameters:
- ADDR_WIDTH, 32, byte-address width.
- INSN_SIZE_BITS, 2, log2 of instruction size in bytes. PCs are word-addressed: [ADDR_WIDTH-1:INSN_SIZE_BITS].
- FETCH_WIDTH, 1, instructions per fetch group. Must be a power of 2, from 1 to 8.
- EPOCH_BITS, 2, width of the redirect epoch counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- rst_pc  in  ADDR_WIDTH-INSN_SIZE_BITS  reset vector (word address)
- out_valid  out  1  out_pc is a valid fetch request
- out_ready  in  1  fetch accepts out_pc this cycle
- out_pc  out  ADDR_WIDTH-INSN_SIZE_BITS  fetch address
- out_epoch  out  EPOCH_BITS  epoch tag sent with out_pc
- exc_valid  in  1  exception/trap redirect request
- exc_pc  in  ADDR_WIDTH-INSN_SIZE_BITS  exception target
- br_valid  in  1  branch mispredict redirect request
- br_pc  in  ADDR_WIDTH-INSN_SIZE_BITS  branch target
- halt_req  in  1  request to stop issuing fetches
- resume  in  1  leave HALT at the held PC
- halted  out  1  FSM is in HALT
- pc_overflow  out  1  sticky flag: sequential advance wrapped past the top of the address space

Behaviour:
- All outputs are registered.
- FSM states: RESET, BOOT, RUN, HALT.
- While rst=1:
  - state=RESET, out_pc=rst_pc, out_valid=0, out_epoch=0, halted=0, pc_overflow=0.
  - rst sampled on any cycle aborts everything in flight, including HALT and pending redirects.
- BOOT: first cycle after rst falls.
  - out_pc=rst_pc (re-sampled), out_valid=1.
  - Go to RUN. The BOOT-cycle PC stays presented until accepted, under the normal handshake.
- Priority each cycle, highest first: rst > exc_valid > br_valid > halt_req > handshake advance.
- Redirect (exc_valid, or br_valid with no exc_valid), in any non-RESET state, including BOOT and HALT:
  - Next cycle: out_pc=target, out_valid=1, out_epoch=out_epoch+1 (wraps modulo 2^EPOCH_BITS), state=RUN.
  - Any unaccepted current out_pc is dropped.
  - Latency from redirect to new out_pc is 1 cycle.
- Handshake in RUN:
  - out_valid=1 and out_ready=1 → next out_pc = (out_pc with low log2(FETCH_WIDTH) bits cleared) + FETCH_WIDTH.
  - out_valid=1 and out_ready=0 → out_pc, out_epoch and out_valid hold stable. out_valid never drops without acceptance except for a redirect, halt_req or rst.
- Advance arithmetic:
  - Unsigned, at word-address width.
  - A carry out of the MSB wraps out_pc to 0 and sets pc_overflow, which stays set until rst.
  - Target PCs are used unaligned as given. Only sequential advance aligns.
- Halt (halt_req=1 with no redirect, in RUN or BOOT):
  - Next cycle: state=HALT, out_valid=0, halted=1.
  - If the current out_pc was accepted in that same cycle, the held PC is the advanced value; otherwise the held PC is the unaccepted out_pc, which is not lost.
- In HALT:
  - out_valid=0; halt_req is ignored.
  - resume=1 → next cycle RUN with out_valid=1 at the held PC, same epoch.
  - A redirect takes priority over resume.
  - resume is ignored outside HALT.
- Simultaneous exc_valid and br_valid → exc_pc wins; epoch increments once.

Decomposition:
- Package nextpc_pkg:
  - state enum nextpc_state_e {RESET, BOOT, RUN, HALT}.
  - Parametrised word-PC width helper constant.
  - Epoch type width.
- One combinational sub-module, pc_group_incr. It takes a PC and FETCH_WIDTH and returns the aligned next-group PC and a carry. It replaces the fixed 16-bit incrementer.
- Everything else (FSM, output registers, sticky flag) lives in next_pc_gen.

Test Plan:
Common configuration: ADDR_WIDTH=16, INSN_SIZE_BITS=2 (14-bit PC), FETCH_WIDTH=4, EPOCH_BITS=2.
- Reset/boot: rst_pc=0x100, rst held 3 cycles then released, out_ready=1 → out_valid=0 during rst; BOOT cycle out_pc=0x100, out_valid=1; then 0x104, 0x108; epoch=0.
- Backpressure and alignment:
  - Redirect to br_pc=0x203, then out_ready=0 for 4 cycles → out_pc=0x203 and out_valid=1 stay stable.
  - After ready: 0x204, then 0x208.
- Redirect priority: exc_valid(0x3000) and br_valid(0x0400) in the same cycle, with an unaccepted out_pc → next out_pc=0x3000, epoch increments by exactly 1. A further 3 redirects wrap the epoch 3→0.
- Halt/resume:
  - halt_req while out_pc=0x110 is unaccepted → halted=1, out_valid=0.
  - resume after 5 cycles → out_pc=0x110, same epoch.
  - Repeat with the PC accepted on the halt cycle → resumes at 0x114.
- Overflow wrap: redirect to 0x3FFC, accept → out_pc=0x0000, pc_overflow=1 and stays set through later redirects; cleared only by rst.
- Reset mid-operation: assert rst while in HALT, with br_valid also high in the same cycle → next state RESET, out_valid=0, epoch=0, halted=0. BOOT then proceeds at rst_pc.

Source files
------------

// File: rtl/next_pc_gen_pkg.sv
// Shared types and width helpers for the fetch-front next-PC generator.
// PCs are word addresses: the byte address with the instruction-size bits dropped.
package nextpc_pkg;

    typedef enum logic [1:0] {
        RESET = 2'd0,
        BOOT  = 2'd1,
        RUN   = 2'd2,
        HALT  = 2'd3
    } nextpc_state_e;

    localparam int DEF_ADDR_WIDTH     = 32;
    localparam int DEF_INSN_SIZE_BITS = 2;
    localparam int DEF_EPOCH_BITS     = 2;

    function automatic int pc_width(input int addr_width, input int insn_size_bits);
        return addr_width - insn_size_bits;
    endfunction

    localparam int DEF_PC_WIDTH = pc_width(DEF_ADDR_WIDTH, DEF_INSN_SIZE_BITS);

    typedef logic [DEF_EPOCH_BITS-1:0] epoch_t;

endpackage

// File: rtl/next_pc_gen_pc_group_incr.sv
// Aligned fetch-group incrementer: clears the in-group offset of pc_i and adds
// FETCH_WIDTH, reporting the carry out of the PC's MSB.
module pc_group_incr #(
    parameter int PC_WIDTH    = 30,
    parameter int FETCH_WIDTH = 1
) (
    input  logic [PC_WIDTH-1:0] pc_i,
    output logic [PC_WIDTH-1:0] next_pc_o,
    output logic                carry_o
);

    localparam logic [PC_WIDTH-1:0] GROUP_MASK = PC_WIDTH'(FETCH_WIDTH - 1);
    localparam logic [PC_WIDTH:0]   GROUP_STEP = (PC_WIDTH + 1)'(FETCH_WIDTH);

    logic [PC_WIDTH-1:0] aligned_pc;
    logic [PC_WIDTH:0]   sum;

    assign aligned_pc = pc_i & ~GROUP_MASK;
    assign sum        = {1'b0, aligned_pc} + GROUP_STEP;

    assign next_pc_o = sum[PC_WIDTH-1:0];
    assign carry_o   = sum[PC_WIDTH];

endmodule

// File: rtl/next_pc_gen.sv
// Next fetch-PC generator: boot sequencing, valid/ready handshake, prioritised
// exception/branch redirects with an epoch tag, and debug/WFI halt.
//
// state | meaning
// RESET | rst seen; outputs idle, PC parked at rst_pc
// BOOT  | first request: rst_pc presented with out_valid
// RUN   | issuing sequential fetch groups
// HALT  | no requests; PC held until resume or redirect
module next_pc_gen
    import nextpc_pkg::*;
#(
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int INSN_SIZE_BITS = DEF_INSN_SIZE_BITS,
    parameter int FETCH_WIDTH    = 1,
    parameter int EPOCH_BITS     = DEF_EPOCH_BITS
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [ADDR_WIDTH-INSN_SIZE_BITS-1:0] rst_pc,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [ADDR_WIDTH-INSN_SIZE_BITS-1:0] out_pc,
    output logic [EPOCH_BITS-1:0]                out_epoch,
    input  logic                                 exc_valid,
    input  logic [ADDR_WIDTH-INSN_SIZE_BITS-1:0] exc_pc,
    input  logic                                 br_valid,
    input  logic [ADDR_WIDTH-INSN_SIZE_BITS-1:0] br_pc,
    input  logic                                 halt_req,
    input  logic                                 resume,
    output logic                                 halted,
    output logic                                 pc_overflow
);

    localparam int PC_W = pc_width(ADDR_WIDTH, INSN_SIZE_BITS);

    nextpc_state_e   state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            valid_q, valid_d;
    logic [EPOCH_BITS-1:0] epoch_q, epoch_d;
    logic            halted_q, halted_d;
    logic            ovf_q, ovf_d;

    logic [PC_W-1:0] adv_pc;
    logic            adv_carry;
    logic            accept;

    pc_group_incr #(
        .PC_WIDTH    (PC_W),
        .FETCH_WIDTH (FETCH_WIDTH)
    ) u_incr (
        .pc_i      (pc_q),
        .next_pc_o (adv_pc),
        .carry_o   (adv_carry)
    );

    assign accept = valid_q & out_ready;

    always_ff @(posedge clk) begin
        state_q  <= state_d;
        pc_q     <= pc_d;
        valid_q  <= valid_d;
        epoch_q  <= epoch_d;
        halted_q <= halted_d;
        ovf_q    <= ovf_d;
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        valid_d  = valid_q;
        epoch_d  = epoch_q;
        halted_d = halted_q;
        ovf_d    = ovf_q;

        if (rst) begin
            state_d  = RESET;
            pc_d     = rst_pc;
            valid_d  = 1'b0;
            epoch_d  = '0;
            halted_d = 1'b0;
            ovf_d    = 1'b0;
        end else if (state_q == RESET) begin
            state_d  = BOOT;
            pc_d     = rst_pc;
            valid_d  = 1'b1;
            halted_d = 1'b0;
        end else if (exc_valid || br_valid) begin
            // Redirect drops whatever is presented, accepted or not.
            state_d  = RUN;
            pc_d     = exc_valid ? exc_pc : br_pc;
            valid_d  = 1'b1;
            epoch_d  = epoch_q + EPOCH_BITS'(1);
            halted_d = 1'b0;
        end else if (state_q == HALT) begin
            if (resume) begin
                state_d  = RUN;
                valid_d  = 1'b1;
                halted_d = 1'b0;
            end
        end else begin
            if (accept) begin
                pc_d  = adv_pc;
                ovf_d = ovf_q | adv_carry;
            end
            if (halt_req) begin
                state_d  = HALT;
                valid_d  = 1'b0;
                halted_d = 1'b1;
            end else begin
                state_d = RUN;
            end
        end
    end

    assign out_valid   = valid_q;
    assign out_pc      = pc_q;
    assign out_epoch   = epoch_q;
    assign halted      = halted_q;
    assign pc_overflow = ovf_q;

endmodule

// File: tb/tb_next_pc_gen.sv
// Directed bench for next_pc_gen: 16-bit byte address, 14-bit word PC,
// 4-wide fetch groups, 2-bit epoch.
module tb_next_pc_gen;

    localparam int AW = 16;
    localparam int IS = 2;
    localparam int FW = 4;
    localparam int EB = 2;
    localparam int PW = AW - IS;

    logic          clk = 1'b0;
    logic          rst;
    logic [PW-1:0] rst_pc;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] out_pc;
    logic [EB-1:0] out_epoch;
    logic          exc_valid;
    logic [PW-1:0] exc_pc;
    logic          br_valid;
    logic [PW-1:0] br_pc;
    logic          halt_req;
    logic          resume;
    logic          halted;
    logic          pc_overflow;

    int checks   = 0;
    int failures = 0;

    next_pc_gen #(
        .ADDR_WIDTH     (AW),
        .INSN_SIZE_BITS (IS),
        .FETCH_WIDTH    (FW),
        .EPOCH_BITS     (EB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rst_pc      (rst_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_epoch   (out_epoch),
        .exc_valid   (exc_valid),
        .exc_pc      (exc_pc),
        .br_valid    (br_valid),
        .br_pc       (br_pc),
        .halt_req    (halt_req),
        .resume      (resume),
        .halted      (halted),
        .pc_overflow (pc_overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (out_valid !== 1'b1 && n < 4) begin
            tick();
            n++;
        end
        chk(tag, {31'd0, out_valid}, 32'd1);
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [31:0] pc,
                           input logic [31:0] ep);
        chk({tag, "_valid"}, {31'd0, out_valid}, {31'd0, v});
        chk({tag, "_pc"}, {18'd0, out_pc}, pc);
        chk({tag, "_epoch"}, {30'd0, out_epoch}, ep);
    endtask

    initial begin
        rst = 1'b1; rst_pc = 14'h100; out_ready = 1'b1;
        exc_valid = 1'b0; exc_pc = '0; br_valid = 1'b0; br_pc = '0;
        halt_req = 1'b0; resume = 1'b0;

        // reset and boot
        repeat (3) tick();
        chk_out("rst", 1'b0, 32'h100, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_ovf", {31'd0, pc_overflow}, 32'd0);
        rst = 1'b0;
        wait_valid("boot_wait");
        chk_out("boot", 1'b1, 32'h100, 32'd0);
        tick(); chk_out("seq1", 1'b1, 32'h104, 32'd0);
        tick(); chk_out("seq2", 1'b1, 32'h108, 32'd0);

        // unaligned branch target held under backpressure, then aligned advance
        br_valid = 1'b1; br_pc = 14'h203; out_ready = 1'b0;
        tick(); br_valid = 1'b0;
        chk_out("br", 1'b1, 32'h203, 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick(); chk_out("stall", 1'b1, 32'h203, 32'd1);
        end
        out_ready = 1'b1;
        tick(); chk_out("align1", 1'b1, 32'h204, 32'd1);
        tick(); chk_out("align2", 1'b1, 32'h208, 32'd1);

        // exception beats branch, single epoch step; then epoch wrap
        out_ready = 1'b0;
        exc_valid = 1'b1; exc_pc = 14'h3000; br_valid = 1'b1; br_pc = 14'h0400;
        tick(); exc_valid = 1'b0; br_valid = 1'b0;
        chk_out("prio", 1'b1, 32'h3000, 32'd2);
        br_valid = 1'b1; br_pc = 14'h500;
        tick(); chk_out("ep3", 1'b1, 32'h500, 32'd3);
        br_pc = 14'h600;
        tick(); chk_out("ep_wrap", 1'b1, 32'h600, 32'd0);
        br_pc = 14'h700;
        tick(); chk_out("ep1", 1'b1, 32'h700, 32'd1);
        br_pc = 14'h110;
        tick(); br_valid = 1'b0;
        chk_out("to110", 1'b1, 32'h110, 32'd2);

        // halt with PC not accepted
        halt_req = 1'b1;
        tick(); halt_req = 1'b0;
        chk("halt1_halted", {31'd0, halted}, 32'd1);
        chk("halt1_valid", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b1;
        repeat (4) tick();
        chk("halt1_hold", {31'd0, out_valid}, 32'd0);
        resume = 1'b1;
        tick(); resume = 1'b0; out_ready = 1'b0;
        chk_out("resume1", 1'b1, 32'h110, 32'd2);
        chk("resume1_halted", {31'd0, halted}, 32'd0);

        // halt with PC accepted on the halt cycle
        halt_req = 1'b1; out_ready = 1'b1;
        tick(); halt_req = 1'b0; out_ready = 1'b0;
        chk("halt2_halted", {31'd0, halted}, 32'd1);
        chk("halt2_valid", {31'd0, out_valid}, 32'd0);
        repeat (4) tick();
        resume = 1'b1;
        tick(); resume = 1'b0;
        chk_out("resume2", 1'b1, 32'h114, 32'd2);
        resume = 1'b1;
        tick(); resume = 1'b0;
        chk_out("resume_in_run", 1'b1, 32'h114, 32'd2);

        // sequential wrap sets sticky overflow
        br_valid = 1'b1; br_pc = 14'h3FFC;
        tick(); br_valid = 1'b0;
        chk_out("top", 1'b1, 32'h3FFC, 32'd3);
        chk("ovf_before", {31'd0, pc_overflow}, 32'd0);
        out_ready = 1'b1;
        tick(); out_ready = 1'b0;
        chk_out("wrap", 1'b1, 32'h0, 32'd3);
        chk("ovf_set", {31'd0, pc_overflow}, 32'd1);
        exc_valid = 1'b1; exc_pc = 14'h050;
        tick(); exc_valid = 1'b0;
        chk_out("post_wrap_exc", 1'b1, 32'h050, 32'd0);
        chk("ovf_sticky", {31'd0, pc_overflow}, 32'd1);

        // reset from HALT beats a same-cycle branch
        halt_req = 1'b1;
        tick(); halt_req = 1'b0;
        chk("halt3_halted", {31'd0, halted}, 32'd1);
        rst = 1'b1; br_valid = 1'b1; br_pc = 14'h777;
        tick(); br_valid = 1'b0;
        chk_out("rst2", 1'b0, 32'h100, 32'd0);
        chk("rst2_halted", {31'd0, halted}, 32'd0);
        chk("rst2_ovf", {31'd0, pc_overflow}, 32'd0);
        rst = 1'b0; out_ready = 1'b1;
        wait_valid("boot2_wait");
        chk_out("boot2", 1'b1, 32'h100, 32'd0);
        tick(); chk_out("boot2_seq", 1'b1, 32'h104, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
